alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Multi-cycle issue controller that drives the combinational 16-bit ALU.
//  It accepts 16-bit instructions over a valid/ready handshake and reads operands from
//  an internal 16x16 register file. It drives ALU operands/control, captures the result
//  and writes it back. It is the initiator side of the ALU a/b/alu_control/result interface.
// PARAMETERS
//  DATA_W     16   operand/result/register width (instruction width fixed at 16)
//  REG_RESET  0    reset value of every register-file entry
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  instr_valid  in   1       instr holds a valid instruction
//  instr_ready  out  1       controller can accept (high only in IDLE)
//  instr        in   16      [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt / [7:0] imm
//  alu_a        out  DATA_W  ALU operand a (registered)
//  alu_b        out  DATA_W  ALU operand b (registered)
//  alu_control  out  4       ALU op code (registered; 0 = ALU outputs 0)
//  alu_result   in   DATA_W  ALU combinational result
//  done         out  1       one-cycle pulse: instruction retired
//  illegal      out  1       one-cycle pulse: unsupported opcode dropped
//  dbg_addr     in   4       debug register read address
//  dbg_data     out  DATA_W  combinational read of reg[dbg_addr]; r0 reads 0
// BEHAVIOUR
//  Opcodes: 0x0 NOP; 0x1 ADD; 0x2 SUB; 0x3 AND; 0x4 OR (sent unchanged as alu_control);
//   0x8 LDI rd <= {zero-ext imm8}; all others are illegal.
//  FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE for ALU ops; IDLE -> DECODE -> WB for LDI/NOP;
//   IDLE -> DECODE -> IDLE for illegal opcodes.
//  IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE.
//   With valid low, stay in IDLE.
//  DECODE: read rs/rt (r0=0). For ALU ops, register alu_a=reg[rs], alu_b=reg[rt],
//   alu_control=opcode on the exit edge.
//  EXEC: alu_control/a/b are stable for the whole cycle. Capture alu_result into result_q
//   at the end of EXEC. On entering WB, clear alu_control to 0; alu_a/alu_b hold.
//  WB: on the exit edge write rd (result_q, or imm for LDI). NOP writes nothing.
//   Writes to rd=0 are discarded.
//  done = (state==WB). illegal = (state==DECODE && opcode illegal).
//  Latency, acceptance cycle = 0: ALU op has done in cycle 3 and ready in cycle 4;
//   LDI/NOP has done in cycle 2; illegal has illegal in cycle 1 and ready in cycle 2.
//  Throughput: one instruction per 4 cycles (ALU) / 3 cycles (LDI, NOP).
//  Register forwarding: none is needed, because instructions never overlap.
//  Arithmetic: ALU wraps modulo 2^16; the controller does no extension beyond imm8 zero-ext.
//  A debug read of a reg being written in WB returns the old value; the new value
//   is visible the next cycle.
//  instr is ignored outside IDLE. Changing instr/instr_valid mid-operation has no effect.
//  Reset (asynchronous, any state) sets:
//   - state = IDLE
//   - all registers = REG_RESET
//   - alu_a = alu_b = 0, alu_control = 0
//   - done = illegal = 0
//   - instr_ready = 1 once rst_n is high
//   An in-flight instruction is abandoned with no write.
// TESTING
//  LDI r1,0x34; LDI r2,0x12; ADD r3,r1,r2 -> alu_control=1 in EXEC; done cycle 3; r3=0x0046.
//  LDI r1,0x00; SUB r4,r1,r2 with r2=0x12 -> r4=0xFFEE (wrap); AND/OR r5 check 0x0010/0x0036.
//  Opcode 0xF -> illegal pulses once in cycle 1, done stays 0, no reg changes, ready in cycle 2.
//  ADD r0,r1,r2 -> done pulses, dbg_data(r0)=0; NOP -> done cycle 2, no writes.
//  Hold instr_valid high for back-to-back ADDs -> acceptances exactly 4 cycles apart;
//   instr changes while busy are ignored.
//  Assert rst_n low during EXEC -> alu_control=0, regs=REG_RESET immediately, no done;
//   after release, ready=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller for the 16-bit combinational ALU: it accepts one
// instruction at a time, reads operands from a 16-entry register file, and writes back the ALU or immediate result.
module alu_issue_ctrl #(
    parameter int unsigned       DATA_W    = 16,
    parameter logic [DATA_W-1:0] REG_RESET = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [15:0]       instr_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [3:0]        alu_control_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              done_o,
    output logic              illegal_o,
    input  logic [3:0]        dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB
    } state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h8;

    state_e            state_q, state_d;
    logic [15:0]       instr_q;
    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [3:0]        alu_ctrl_q;

    logic [3:0]        opcode;
    logic [3:0]        rd;
    logic [3:0]        rs;
    logic [3:0]        rt;
    logic [7:0]        imm;
    logic              is_alu;
    logic              is_ldi;
    logic              is_nop;
    logic              is_illegal;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              wb_en;
    logic [DATA_W-1:0] wb_data;

    assign opcode     = instr_q[15:12];
    assign rd         = instr_q[11:8];
    assign rs         = instr_q[7:4];
    assign rt         = instr_q[3:0];
    assign imm        = instr_q[7:0];
    assign is_alu     = (opcode >= OP_ADD) && (opcode <= OP_OR);
    assign is_ldi     = (opcode == OP_LDI);
    assign is_nop     = (opcode == OP_NOP);
    assign is_illegal = !(is_alu || is_ldi || is_nop);

    // r0 is hardwired to zero on every read path, whatever REG_RESET holds.
    assign rs_val = (rs == 4'd0) ? '0 : regs_q[rs];
    assign rt_val = (rt == 4'd0) ? '0 : regs_q[rt];

    assign wb_en   = (state_q == S_WB) && !is_nop && (rd != 4'd0);
    assign wb_data = is_ldi ? DATA_W'(imm) : result_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_ready_o = 1'b0;
        done_o        = 1'b0;
        illegal_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                illegal_o = is_illegal;
                if (is_alu) begin
                    state_d = S_EXEC;
                end else if (is_ldi || is_nop) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ALU controls go inactive as soon as the result is captured; operands hold.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q    <= '0;
            result_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
        end else begin
            if ((state_q == S_IDLE) && instr_valid_i) begin
                instr_q <= instr_i;
            end
            if ((state_q == S_DECODE) && is_alu) begin
                alu_a_q    <= rs_val;
                alu_b_q    <= rt_val;
                alu_ctrl_q <= opcode;
            end
            if (state_q == S_EXEC) begin
                result_q   <= alu_result_i;
                alu_ctrl_q <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= REG_RESET;
            end
        end else if (wb_en) begin
            regs_q[rd] <= wb_data;
        end
    end

    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_control_o = alu_ctrl_q;
    assign dbg_data_o    = (dbg_addr_i == 4'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural ALU, directed program, back-to-back issue,
// reset mid-instruction, and randomized instructions checked against a register-file model.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rstN;
    logic        instrValid;
    logic        instrReady;
    logic [15:0] instr;
    logic [15:0] aluA;
    logic [15:0] aluB;
    logic [3:0]  aluControl;
    logic [15:0] aluResult;
    logic        done;
    logic        illegal;
    logic [3:0]  dbgAddr;
    logic [15:0] dbgData;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] refRegs [16];

    alu_issue_ctrl #(.DATA_W(16), .REG_RESET(16'h0000)) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .instr_valid_i (instrValid),
        .instr_ready_o (instrReady),
        .instr_i       (instr),
        .alu_a_o       (aluA),
        .alu_b_o       (aluB),
        .alu_control_o (aluControl),
        .alu_result_i  (aluResult),
        .done_o        (done),
        .illegal_o     (illegal),
        .dbg_addr_i    (dbgAddr),
        .dbg_data_o    (dbgData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational ALU on the far side of the interface.
    always_comb begin
        aluResult = 16'h0000;
        case (aluControl)
            4'h1: aluResult = aluA + aluB;
            4'h2: aluResult = aluA - aluB;
            4'h3: aluResult = aluA & aluB;
            4'h4: aluResult = aluA | aluB;
            default: aluResult = 16'h0000;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic readReg(input logic [3:0] a, output logic [15:0] v);
        dbgAddr = a;
        #1;
        v = dbgData;
    endtask

    function automatic logic [15:0] refRead(input logic [3:0] a);
        return (a == 4'd0) ? 16'h0000 : refRegs[a];
    endfunction

    function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int rt);
        return {op[3:0], rd[3:0], rs[3:0], rt[3:0]};
    endfunction

    function automatic logic [15:0] mkLdi(input int rd, input int imm);
        return {4'h8, rd[3:0], imm[7:0]};
    endfunction

    // Architectural effect of one retired instruction on the register-file model.
    task automatic modelRetire(input logic [15:0] ins);
        int a;
        int b;
        int r;
        a = refRead(ins[7:4]);
        b = refRead(ins[3:0]);
        r = -1;
        case (ins[15:12])
            4'h1: r = (a + b) % 65536;
            4'h2: r = (a - b + 65536) % 65536;
            4'h3: r = a & b;
            4'h4: r = a | b;
            4'h8: r = ins[7:0];
            default: r = -1;
        endcase
        if (r >= 0 && ins[11:8] != 4'd0) begin
            refRegs[ins[11:8]] = r[15:0];
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 16; i++) refRegs[i] = 16'h0000;
    endtask

    task automatic applyStimulus(input logic [15:0] ins);
        logic [3:0]  op;
        logic [15:0] v;
        bit          isAlu;
        bit          isSimple;
        bit          writes;
        int          doneCyc;
        int          lastCyc;
        int          waitCyc;
        logic [15:0] aVal;
        logic [15:0] bVal;
        op       = ins[15:12];
        isAlu    = (op >= 4'h1 && op <= 4'h4);
        isSimple = (op == 4'h0 || op == 4'h8);
        writes   = (isAlu || op == 4'h8) && ins[11:8] != 4'd0;
        doneCyc  = isAlu ? 3 : (isSimple ? 2 : -1);
        lastCyc  = isAlu ? 4 : (isSimple ? 3 : 2);
        aVal     = refRead(ins[7:4]);
        bVal     = refRead(ins[3:0]);
        waitCyc  = 0;
        @(negedge clk);
        while (!instrReady && waitCyc < 10) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("ready_before_issue", instrReady, 1);
        instrValid = 1'b1;
        instr      = ins;
        @(posedge clk);
        #1;
        instrValid = 1'($urandom_range(0, 1));
        instr      = 16'($urandom);
        for (int c = 1; c <= lastCyc; c++) begin
            @(negedge clk);
            if (c == lastCyc) instrValid = 1'b0;
            checkOutput("ready", instrReady, (c == lastCyc) ? 1 : 0);
            checkOutput("done", done, (c == doneCyc) ? 1 : 0);
            checkOutput("illegal", illegal, (!isAlu && !isSimple && c == 1) ? 1 : 0);
            checkOutput("alu_control", aluControl, (isAlu && c == 2) ? 32'(op) : 0);
            if (isAlu && (c == 2 || c == 3)) begin
                checkOutput("alu_a", aluA, aVal);
                checkOutput("alu_b", aluB, bVal);
            end
            if (c == doneCyc && writes) begin
                readReg(ins[11:8], v);
                checkOutput("wb_old_value", v, refRegs[ins[11:8]]);
            end
        end
        modelRetire(ins);
        readReg(ins[11:8], v);
        checkOutput("rd_after", v, refRead(ins[11:8]));
    endtask

    task automatic checkAllRegs(input string tag);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            readReg(4'(i), v);
            checkOutput(tag, v, refRead(4'(i)));
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] plan [3];
        int          acc [3];
        int          k;
        rstN       = 1'b0;
        instrValid = 1'b0;
        instr      = 16'h0000;
        dbgAddr    = 4'd0;
        resetModel();
        #1;
        checkOutput("rst_done", done, 0);
        checkOutput("rst_illegal", illegal, 0);
        checkOutput("rst_alu_control", aluControl, 0);
        checkOutput("rst_alu_a", aluA, 0);
        checkOutput("rst_alu_b", aluB, 0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("rst_ready", instrReady, 1);
        checkAllRegs("rst_regs");

        $display("[TB] directed program");
        applyStimulus(mkLdi(1, 'h34));
        applyStimulus(mkLdi(2, 'h12));
        applyStimulus(mk(1, 3, 1, 2));
        readReg(3, v); checkOutput("add_r3", v, 16'h0046);
        applyStimulus(mkLdi(1, 'h00));
        applyStimulus(mk(2, 4, 1, 2));
        readReg(4, v); checkOutput("sub_wrap_r4", v, 16'hFFEE);
        applyStimulus(mkLdi(1, 'h34));
        applyStimulus(mk(3, 5, 1, 2));
        readReg(5, v); checkOutput("and_r5", v, 16'h0010);
        applyStimulus(mk(4, 5, 1, 2));
        readReg(5, v); checkOutput("or_r5", v, 16'h0036);
        applyStimulus(16'hF123);
        checkAllRegs("illegal_no_write");
        applyStimulus(mk(1, 0, 1, 2));
        readReg(0, v); checkOutput("r0_zero", v, 16'h0000);
        applyStimulus(16'h0ABC);
        checkAllRegs("nop_no_write");

        $display("[TB] back-to-back issue");
        plan[0] = mk(1, 6, 1, 2);
        plan[1] = mk(1, 7, 6, 6);
        plan[2] = mk(1, 8, 7, 1);
        k = 0;
        @(negedge clk);
        instrValid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (instrReady) begin
                if (k < 3) begin
                    instr  = plan[k];
                    acc[k] = c;
                    k++;
                end else begin
                    instrValid = 1'b0;
                end
            end else begin
                instr = 16'($urandom);
            end
        end
        instrValid = 1'b0;
        checkOutput("b2b_count", k, 3);
        if (k == 3) begin
            checkOutput("b2b_gap1", acc[1] - acc[0], 4);
            checkOutput("b2b_gap2", acc[2] - acc[1], 4);
        end
        for (int i = 0; i < 3; i++) modelRetire(plan[i]);
        checkAllRegs("b2b_regs");

        $display("[TB] reset during EXEC");
        @(negedge clk);
        instr      = mk(1, 9, 1, 2);
        instrValid = 1'b1;
        @(posedge clk);
        #1;
        instrValid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("exec_ctrl_before_rst", aluControl, 1);
        rstN = 1'b0;
        #1;
        resetModel();
        checkOutput("mid_rst_ctrl", aluControl, 0);
        checkOutput("mid_rst_alu_a", aluA, 0);
        checkOutput("mid_rst_done", done, 0);
        readReg(1, v); checkOutput("mid_rst_r1", v, 16'h0000);
        @(negedge clk);
        rstN = 1'b1;
        #1;
        checkOutput("post_rst_ready", instrReady, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("post_rst_no_done", done, 0);
        end
        checkAllRegs("post_rst_regs");

        $display("[TB] randomized instructions");
        for (int n = 0; n < 60; n++) begin
            int sel;
            int op;
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = 0;
                5, 6: op = 8;
                7: begin
                    op = $urandom_range(5, 15);
                    if (op == 8) op = 15;
                end
                default: op = sel;
            endcase
            if (op == 8) applyStimulus(mkLdi($urandom_range(0, 15), $urandom_range(0, 255)));
            else applyStimulus(mk(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)));
        end
        checkAllRegs("final_regs");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
